// File: rtl/count_sequencer.sv
// count_sequencer: run-control FSM for the loadable custom-sequence counter.
// Turns four active-low push buttons into one-cycle load/tick strobes, divides
// CLOCK_50 into the visible count rate and can auto-halt on a programmed value.
// Optional feature: define KEY_DEBOUNCE_EN to insert a DEB_CYCLES debouncer
// between each key synchronizer and its press detector.
module count_sequencer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             key_start_n,
    input  logic             key_stop_n,
    input  logic             key_step_n,
    input  logic             key_load_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic             stop_match_en,
    input  logic [WIDTH-1:0] count_q,
    output logic             cnt_tick,
    output logic             cnt_load,
    output logic [2:0]       state,
    output logic             running,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_STEP  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LP_PRE_TERM = PW'(TICK_DIV - 1);

    // Key bit order: [3]=load [2]=stop [1]=start [0]=step
    logic [3:0] w_key_n;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_lvl;
    logic [3:0] r_prev;
    logic [3:0] w_press;

    logic w_ev_load;
    logic w_ev_stop;
    logic w_ev_start;
    logic w_ev_step;
    logic w_match;

    state_t        r_state;
    state_t        w_state_nx;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nx;
    logic          r_tick;
    logic          w_tick_nx;
    logic          r_load;
    logic          w_load_nx;
    logic          r_running;
    logic          r_halted;

    // load_val goes straight to the counter; it is only on this port list for wiring
    logic w_unused;

    assign w_key_n = {key_load_n, key_stop_n, key_start_n, key_step_n};

    // Two-flop synchronizer for the asynchronous push buttons
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_key_n;
            r_sync2 <= r_sync1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] LP_DEB_TERM = DW'(DEB_CYCLES - 1);

    logic [3:0]    r_deb;
    logic [DW-1:0] r_deb_cnt [4];

    // Accept a new key level only after it has differed for DEB_CYCLES cycles in a row
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == LP_DEB_TERM) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_lvl    = r_deb;
    assign w_unused = ^load_val;
`else
    assign w_lvl    = r_sync2;
    assign w_unused = (^load_val) ^ (DEB_CYCLES == 0);
`endif

    // Remember last key level so a press is a single 1->0 pulse
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '1;
        end else begin
            r_prev <= w_lvl;
        end
    end

    assign w_press = r_prev & ~w_lvl;

    // Only the highest-priority press of a cycle survives
    assign w_ev_load  = w_press[3];
    assign w_ev_stop  = w_press[2] & ~w_press[3];
    assign w_ev_start = w_press[1] & ~(|w_press[3:2]);
    assign w_ev_step  = w_press[0] & ~(|w_press[3:1]);

    assign w_match = stop_match_en && (count_q == stop_val);

    // Next-state, prescaler and strobe decode
    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_tick_nx  = 1'b0;
        w_load_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ev_load) begin
                    w_state_nx = S_LOAD;
                    w_presc_nx = '0;
                    w_load_nx  = 1'b1;
                end else if (w_ev_start) begin
                    w_state_nx = S_RUN;
                    w_presc_nx = '0;
                end else if (w_ev_step) begin
                    w_state_nx = S_STEP;
                    w_tick_nx  = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nx = S_IDLE;
                w_presc_nx = '0;
            end
            S_RUN: begin
                // Auto-halt outranks stop and the tick; only load beats it
                if (w_ev_load) begin
                    w_state_nx = S_LOAD;
                    w_presc_nx = '0;
                    w_load_nx  = 1'b1;
                end else if (w_match) begin
                    w_state_nx = S_HALT;
                end else if (w_ev_stop) begin
                    w_state_nx = S_PAUSE;
                end else if (r_presc == LP_PRE_TERM) begin
                    w_presc_nx = '0;
                    w_tick_nx  = 1'b1;
                end else begin
                    w_presc_nx = r_presc + 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_ev_load) begin
                    w_state_nx = S_LOAD;
                    w_presc_nx = '0;
                    w_load_nx  = 1'b1;
                end else if (w_ev_start) begin
                    w_state_nx = S_RUN;
                end else if (w_ev_step) begin
                    w_state_nx = S_STEP;
                    w_tick_nx  = 1'b1;
                end
            end
            S_STEP: begin
                w_state_nx = S_PAUSE;
            end
            S_HALT: begin
                if (w_ev_load) begin
                    w_state_nx = S_LOAD;
                    w_presc_nx = '0;
                    w_load_nx  = 1'b1;
                end else if (w_ev_start) begin
                    if (!w_match) begin
                        w_state_nx = S_RUN;
                    end
                end else if (w_ev_step) begin
                    w_state_nx = S_STEP;
                    w_tick_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_presc_nx = '0;
            end
        endcase
    end

    // State, prescaler and registered outputs
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_load    <= 1'b0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_presc   <= w_presc_nx;
            r_tick    <= w_tick_nx;
            r_load    <= w_load_nx;
            r_running <= (w_state_nx == S_RUN);
            r_halted  <= (w_state_nx == S_HALT);
        end
    end

    assign cnt_tick = r_tick;
    assign cnt_load = r_load;
    assign state    = r_state;
    assign running  = r_running;
    assign halted   = r_halted;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer (TICK_DIV=4, DEB_CYCLES=8, WIDTH=4) plus a
// TICK_DIV=1 instance sharing the same stimulus. Debounce cases run when
// KEY_DEBOUNCE_EN is defined.
module tb_count_sequencer;

`ifdef KEY_DEBOUNCE_EN
    localparam int L = 8;
`else
    localparam int L = 0;
`endif
    localparam int GAP = 4 + L;

    localparam logic [3:0] K_STEP  = 4'b0001;
    localparam logic [3:0] K_START = 4'b0010;
    localparam logic [3:0] K_STOP  = 4'b0100;
    localparam logic [3:0] K_LOAD  = 4'b1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] keys_n;
    logic [3:0] load_val;
    logic [3:0] stop_val;
    logic       en;
    logic [3:0] count_q;

    logic       tick, load, running, halted;
    logic [2:0] state;
    logic       tick1, load1, running1, halted1;
    logic [2:0] state1;

    int n_vec     = 0;
    int n_miss    = 0;
    int gap_ticks = 0;

    always #10 clk = ~clk;

    count_sequencer #(.WIDTH(4), .TICK_DIV(4), .DEB_CYCLES(8)) u_dut (
        .CLOCK_50(clk), .rst_n(rst_n),
        .key_start_n(keys_n[1]), .key_stop_n(keys_n[2]),
        .key_step_n(keys_n[0]), .key_load_n(keys_n[3]),
        .load_val(load_val), .stop_val(stop_val), .stop_match_en(en),
        .count_q(count_q),
        .cnt_tick(tick), .cnt_load(load), .state(state),
        .running(running), .halted(halted)
    );

    count_sequencer #(.WIDTH(4), .TICK_DIV(1), .DEB_CYCLES(8)) u_dut_div1 (
        .CLOCK_50(clk), .rst_n(rst_n),
        .key_start_n(keys_n[1]), .key_stop_n(keys_n[2]),
        .key_step_n(keys_n[0]), .key_load_n(keys_n[3]),
        .load_val(load_val), .stop_val(stop_val), .stop_match_en(en),
        .count_q(count_q),
        .cnt_tick(tick1), .cnt_load(load1), .state(state1),
        .running(running1), .halted(halted1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Hold keys low from a negedge; returns at the negedge after the state update
    task automatic press(input logic [3:0] mask);
        keys_n = keys_n & ~mask;
        repeat (3 + L) @(negedge clk);
        keys_n = '1;
    endtask

    task automatic gap();
        repeat (GAP) begin
            @(negedge clk);
            if (tick) gap_ticks++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        keys_n   = '1;
        load_val = 4'd9;
        stop_val = 4'd5;
        en       = 1'b0;
        count_q  = 4'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_tick", tick, 0);
        chk("rst_load", load, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", state, 0);

        // load: pulse appears two edges after the first sampling edge
        keys_n = ~K_LOAD;
        repeat (2 + L) @(negedge clk);
        chk("load_latency", state, 0);
        @(negedge clk);
        chk("load_state", state, 1);
        chk("load_pulse", load, 1);
        chk("load_no_tick", tick, 0);
        keys_n = '1;
        @(negedge clk);
        chk("load_back_idle", state, 0);
        chk("load_pulse_end", load, 0);
        gap();

        // run: tick every 4th cycle; TICK_DIV=1 ticks every cycle
        press(K_START);
        chk("run_state", state, 2);
        chk("run_running", running, 1);
        chk("run_first_tick", tick, 0);
        chk("div1_first_tick", tick1, 0);
        chk("div1_running", running1, 1);
        chk("div1_halted", halted1, 0);
        chk("div1_load", load1, 0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("run_tick_%0d", i), tick, (i % 4 == 0) ? 1 : 0);
            chk($sformatf("div1_tick_%0d", i), tick1, 1);
        end
        // stop lands with prescaler at 2; resume ticks after 2 cycles
        press(K_STOP);
        chk("pause_state", state, 3);
        chk("pause_tick", tick, 0);
        chk("pause_running", running, 0);
        gap_ticks = 0;
        gap();
        chk("pause_no_ticks", gap_ticks, 0);
        press(K_START);
        chk("resume_state", state, 2);
        chk("resume_tick0", tick, 0);
        @(negedge clk);
        chk("resume_tick1", tick, 0);
        @(negedge clk);
        chk("resume_tick2", tick, 1);
        gap();

        // single steps from PAUSE
        press(K_STOP);
        chk("pause2_state", state, 3);
        gap_ticks = 0;
        gap();
        for (int i = 0; i < 3; i++) begin
            press(K_STEP);
            chk($sformatf("step%0d_state", i), state, 4);
            chk($sformatf("step%0d_tick", i), tick, 1);
            @(negedge clk);
            chk($sformatf("step%0d_back", i), state, 3);
            chk($sformatf("step%0d_tick_end", i), tick, 0);
            gap();
        end
        chk("step_extra_ticks", gap_ticks, 0);

        // auto-halt exactly in the cycle a tick would be issued
        press(K_LOAD);
        chk("reload_state", state, 1);
        gap();
        en = 1'b1;
        press(K_START);
        chk("halt_run_state", state, 2);
        repeat (3) @(negedge clk);
        count_q = 4'd5;
        @(negedge clk);
        chk("halt_state", state, 5);
        chk("halt_flag", halted, 1);
        chk("halt_running", running, 0);
        chk("halt_no_tick", tick, 0);
        gap();
        press(K_START);
        chk("halt_start_ignored", state, 5);
        gap();
        press(K_LOAD);
        chk("halt_load_state", state, 1);
        chk("halt_load_pulse", load, 1);
        count_q = 4'd9;
        @(negedge clk);
        chk("halt_load_idle", state, 0);
        gap();
        press(K_START);
        chk("halt_restart", state, 2);
        chk("halt_restart_run", running, 1);
        chk("halt_restart_flag", halted, 0);
        en      = 1'b0;
        count_q = 4'd5;
        repeat (3) @(negedge clk);
        chk("match_disabled_run", state, 2);
        count_q = 4'd0;
        gap();

        // load and start together: load wins
        press(K_LOAD | K_START);
        chk("prio_state", state, 1);
        chk("prio_load", load, 1);
        chk("prio_tick", tick, 0);
        @(negedge clk);
        chk("prio_idle", state, 0);
        gap();
        chk("prio_no_run", state, 0);

        // async reset while cnt_tick is high
        press(K_START);
        chk("rst_run_state", state, 2);
        repeat (4) @(negedge clk);
        chk("rst_pre_tick", tick, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_tick", tick, 0);
        chk("rst_async_state", state, 0);
        chk("rst_async_running", running, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_release_state", state, 0);
        chk("rst_release_tick", tick, 0);

`ifdef KEY_DEBOUNCE_EN
        keys_n = ~K_START;
        repeat (5) @(negedge clk);
        keys_n = '1;
        repeat (20) @(negedge clk);
        chk("deb_glitch_state", state, 0);
        keys_n = ~K_START;
        repeat (10) @(negedge clk);
        keys_n = '1;
        repeat (20) @(negedge clk);
        chk("deb_press_state", state, 2);
        chk("deb_press_running", running, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
